// File: rtl/capture_tracker_if.sv
// Bundles the game-side signals of capture_tracker.
//   master : game FSM / random source side (drives i_*, observes o_*)
//   slave  : capture_tracker side (observes i_*, drives o_*)
// Signals:
//   i_restart       synchronous clear of all tracker state
//   i_refresh       one-cycle strobe: commit pending capture, latch new target
//   i_random        random value sampled on i_refresh
//   i_capture       capture request, qualified by i_refresh
//   o_capture       bitmap of captured slots
//   o_count         population count of o_capture
//   o_target        latched target slot index
//   o_target_valid  latched target is below N_SLOTS
//   o_new / o_dup   one-cycle result pulses of a capture
//   o_all           every slot captured (level)
interface capture_tracker_if #(
  parameter int unsigned N_SLOTS = 7,
  parameter int unsigned IDX_W   = 3
);
  localparam int unsigned CNT_W = $clog2(N_SLOTS + 1);

  logic               i_restart;
  logic               i_refresh;
  logic [IDX_W-1:0]   i_random;
  logic               i_capture;
  logic [N_SLOTS-1:0] o_capture;
  logic [CNT_W-1:0]   o_count;
  logic [IDX_W:0]     o_target;
  logic               o_target_valid;
  logic               o_new;
  logic               o_dup;
  logic               o_all;

  modport master (
    output i_restart, i_refresh, i_random, i_capture,
    input  o_capture, o_count, o_target, o_target_valid, o_new, o_dup, o_all
  );

  modport slave (
    input  i_restart, i_refresh, i_random, i_capture,
    output o_capture, o_count, o_target, o_target_valid, o_new, o_dup, o_all
  );
endinterface

// File: rtl/capture_tracker.sv
// Collection tracker: keeps an N_SLOTS-wide bitmap of captured slots, latches a random
// target on every refresh and commits a capture against the target latched at the
// previous refresh. Reports new/duplicate pulses, a capture count and an all-captured
// terminal state.
// Ports:
//   i_clk    system clock, all state on rising edge
//   i_rst_n  synchronous active-low reset
//   bus      capture_tracker_if.slave (restart/refresh/random/capture in, status out)
module capture_tracker #(
  parameter int unsigned N_SLOTS  = 7,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned SLOT_OFS = 0
) (
  input logic               i_clk,
  input logic               i_rst_n,
  capture_tracker_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(N_SLOTS + 1);

  typedef enum logic [1:0] {StIdle, StArmed, StDone} state_e;

  state_e             state_q, state_d;
  logic [N_SLOTS-1:0] capture_q, capture_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W:0]     target_q, target_d;
  logic               target_valid_q, target_valid_d;
  logic               new_q, new_d;
  logic               dup_q, dup_d;

  logic [IDX_W:0]     target_sum;
  logic               target_ok;
  logic [N_SLOTS-1:0] slot_mask;
  logic               slot_hit;

  // One extra bit keeps the offset sum from wrapping; out-of-range sums are flagged invalid.
  assign target_sum = {1'b0, bus.i_random} + (IDX_W + 1)'(SLOT_OFS);
  assign target_ok  = 32'(target_sum) < N_SLOTS;

  // Mask of the previously latched target; only consulted when that target was valid.
  assign slot_mask = {{(N_SLOTS - 1){1'b0}}, 1'b1} << target_q;
  assign slot_hit  = |(capture_q & slot_mask);

  always_comb begin
    state_d        = state_q;
    capture_d      = capture_q;
    count_d        = count_q;
    target_d       = target_q;
    target_valid_d = target_valid_q;
    new_d          = 1'b0;
    dup_d          = 1'b0;

    if (bus.i_restart) begin
      state_d        = StIdle;
      capture_d      = '0;
      count_d        = '0;
      target_d       = '0;
      target_valid_d = 1'b0;
    end else if (bus.i_refresh) begin
      unique case (state_q)
        StIdle: begin
          target_d       = target_sum;
          target_valid_d = target_ok;
          state_d        = StArmed;
        end
        StArmed: begin
          target_d       = target_sum;
          target_valid_d = target_ok;
          if (bus.i_capture && target_valid_q) begin
            if (slot_hit) begin
              dup_d = 1'b1;
            end else begin
              capture_d = capture_q | slot_mask;
              count_d   = count_q + CNT_W'(1);
              new_d     = 1'b1;
              if (count_q == CNT_W'(N_SLOTS - 1)) begin
                state_d = StDone;
              end
            end
          end
        end
        StDone: begin
          // Terminal: everything held until reset or restart.
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q        <= StIdle;
      capture_q      <= '0;
      count_q        <= '0;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      new_q          <= 1'b0;
      dup_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      capture_q      <= capture_d;
      count_q        <= count_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      new_q          <= new_d;
      dup_q          <= dup_d;
    end
  end

  assign bus.o_capture      = capture_q;
  assign bus.o_count        = count_q;
  assign bus.o_target       = target_q;
  assign bus.o_target_valid = target_valid_q;
  assign bus.o_new          = new_q;
  assign bus.o_dup          = dup_q;
  assign bus.o_all          = (state_q == StDone);
endmodule

// File: doc/capture_tracker.md
Name: capture_tracker

Overview:
Parametrised successor to the single-flag capture memory. It keeps an N_SLOTS-wide collection bitmap, latches a random target on each refresh, and commits a capture against the previously latched target. It adds range checking, duplicate detection, a capture counter, one-cycle event pulses and an all-captured terminal state. It sits between the random generator / game FSM and the display/score logic.

Parameters:
N_SLOTS, 7, number of collectable slots (2..64)
IDX_W, 3, width of i_random
SLOT_OFS, 0, constant added to i_random to form the target slot index (computed at IDX_W+1 bits)
CNT_W, $clog2(N_SLOTS+1), width of o_count (derived, do not override)

Ports:
i_clk  in  1  system clock, all state on rising edge
i_rst_n  in  1  synchronous active-low reset
i_restart  in  1  synchronous clear of all state (game restart)
i_refresh  in  1  one-cycle strobe: commit pending capture, latch new target
i_random  in  IDX_W  random value sampled on i_refresh
i_capture  in  1  sampled only with i_refresh; request to capture current target
o_capture  out  N_SLOTS  bitmap of captured slots, bit k = slot k
o_count  out  CNT_W  number of set bits in o_capture
o_target  out  IDX_W+1  currently latched target slot index
o_target_valid  out  1  latched target is in range (< N_SLOTS)
o_new  out  1  one-cycle pulse: a previously empty slot was captured
o_dup  out  1  one-cycle pulse: capture hit an already-set slot
o_all  out  1  all N_SLOTS captured (level)

Behaviour:
- Reset (i_rst_n=0 at clock edge) and restart (i_restart=1) have identical effect. All outputs go to 0, state goes to S_IDLE.
- Priority at a clock edge: reset > restart > refresh.
- States:
  - S_IDLE: no target held. On i_refresh, latch o_target=i_random+SLOT_OFS and o_target_valid=(that value < N_SLOTS), then go to S_ARMED. i_capture is ignored; no pulses.
  - S_ARMED: on i_refresh:
    - If i_capture and o_target_valid:
      - Slot already set: o_dup=1 next cycle; bitmap and count unchanged.
      - Slot empty: set the bit, o_count+=1, o_new=1 next cycle.
    - If i_capture with an invalid target, or no i_capture: bitmap unchanged, no pulse.
    - In all cases, latch the new target from i_random in the same edge.
    - If this capture makes o_count==N_SLOTS, go to S_DONE in the same edge.
  - S_DONE: o_all=1. i_refresh and i_capture are ignored; target, bitmap and count are held. Only reset or restart exit, to S_IDLE.
- Capture applies to the target latched at the previous refresh, never to the i_random value arriving in the same cycle.
- Latency:
  - Bitmap, count, o_all and pulses update at the refresh edge.
  - o_new and o_dup are high for exactly one cycle after that edge and are mutually exclusive.
  - o_all rises in the same cycle o_count reaches N_SLOTS.
- Width rules:
  - Target sum is computed at IDX_W+1 bits with no wrap.
  - o_count never exceeds N_SLOTS and never decrements except through reset or restart.
- Without i_refresh, nothing changes and pulses are 0.
- Reset or restart mid-operation clears pulses in flight: if asserted at the edge after a capture, o_new/o_dup are 0.
- Back-to-back refreshes on consecutive cycles are legal; each is processed independently.

Test Plan:
- Reset with N_SLOTS=7, SLOT_OFS=0: hold i_rst_n=0 for 2 clocks -> o_capture=0, o_count=0, o_target_valid=0, o_new/o_dup/o_all=0.
- From idle:
  - Refresh random=3 capture=1 -> no capture, o_target=3 valid.
  - Next, refresh random=5 capture=1 -> o_capture=7'b0001000, o_count=1, o_new one cycle, o_target=5.
- Duplicate: capture slot 5 with the next refresh random=5, then refresh capture=1 -> o_dup one cycle, o_count=2 unchanged, o_new=0.
- Out of range:
  - Refresh random=7 -> o_target_valid=0.
  - Next refresh capture=1 -> bitmap and count unchanged, no pulses.
- SLOT_OFS=1: random=6 -> o_target=7, invalid; random=0 -> slot 1 captured on the next refresh.
- Fill:
  - Capture slots 0..6 -> o_all=1 and o_count=7 on the edge of the 7th capture.
  - Further refresh/capture -> all outputs held.
- Restart together with i_refresh and i_capture on a valid empty target -> all cleared, S_IDLE, no o_new.
- Reset asserted the edge after a capture -> o_new stays 0.
